fetch_unit: RTL and testbench

Instruction fetch stage feeding the single-cycle MIPS decode/control path.
- Owns the PC and issues one outstanding instruction-memory request at a time over a req/ack handshake.
- Holds the returned word and presents op/funct to the controller.
- Computes the next PC from the controller's pcsrc/jump once the held instruction is consumed.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 10 +
 rtl/pc_next.sv | 25 ++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch stage: FSM states, MIPS field
// positions and the default reset PC.
package fetch_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int JIDX_MSB  = 25;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus. master = fetch unit, slave = memory.
interface fetch_unit_if #(parameter int ADDR_W = 32);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select: jump > branch > sequential.
module pc_next
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc4_i,
  input  logic [JIDX_MSB:0] jidx_i,
  input  logic [ADDR_W-1:0] pcbranch_i,
  input  logic              pcsrc_i,
  input  logic              jump_i,
  output logic [ADDR_W-1:0] next_pc_o
);
  localparam logic [ADDR_W-1:0] JMASK = ADDR_W'(32'h0FFF_FFFF);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(3);

  // jump keeps the pc4 region bits; branch targets are word-aligned by force
  always_comb begin
    next_pc_o = pc4_i;
    if (jump_i)
      next_pc_o = (pc4_i & ~JMASK) | ADDR_W'({jidx_i, 2'b00});
    else if (pcsrc_i)
      next_pc_o = pcbranch_i & ~AMASK;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// holds the returned word for the controller and advances on consume.
// Optional build macro FETCH_PERF_EN adds perf_instret / perf_wait counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      imem,
  input  logic              stall,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] pcbranch,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_instret,
  output logic [31:0]       perf_wait
`endif
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
  logic [31:0]       instr_q, instr_d;
  logic              req_q, req_d;
  logic              accept, consume;

  assign accept  = (state_q == REQ) && imem.imem_ack;
  assign consume = (state_q == HOLD) && !stall;

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc4_i      (pc4),
    .jidx_i     (instr_q[JIDX_MSB:0]),
    .pcbranch_i (pcbranch),
    .pcsrc_i    (pcsrc),
    .jump_i     (jump),
    .next_pc_o  (next_pc)
  );

  // next state: IDLE always requests, REQ waits for ack, HOLD waits for !stall
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (accept) begin
              state_d = HOLD;
              instr_d = imem.imem_rdata;
            end
      HOLD: if (consume) begin
              state_d = REQ;
              pc_d    = next_pc;
            end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  // state, PC, held word and request flop; reset drops everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign op             = instr_q[OP_MSB:OP_LSB];
  assign funct          = instr_q[FUNCT_MSB:0];
  assign instr_valid    = (state_q == HOLD);
  assign pc             = pc_q;
  assign pc4            = pc_q + ADDR_W'(4);

`ifdef FETCH_PERF_EN
  logic [31:0] instret_q, wait_q;

  // retired count per consume; wait count per starved REQ or stalled HOLD cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      if (consume) instret_q <= instret_q + 32'd1;
      if (((state_q == REQ) && !imem.imem_ack) || ((state_q == HOLD) && stall))
        wait_q <= wait_q + 32'd1;
    end
  end

  assign perf_instret = instret_q;
  assign perf_wait    = wait_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with a transaction-level PC model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, pcsrc, jump;
  logic [31:0] pcbranch, instr, pc, pc4;
  logic [5:0]  op, funct;
  logic        instr_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_instret, perf_wait;
`endif

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32)) bus();

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem(bus),
    .stall(stall), .pcsrc(pcsrc), .jump(jump), .pcbranch(pcbranch),
    .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
    .pc(pc), .pc4(pc4)
`ifdef FETCH_PERF_EN
    , .perf_instret(perf_instret), .perf_wait(perf_wait)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc, exp_instret, exp_wait;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic j, input logic s,
                                           input logic [31:0] br);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (s) return br & 32'hFFFF_FFFC;
    return p4;
  endfunction

  task automatic chk_perf;
`ifdef FETCH_PERF_EN
    chk("perf_instret", perf_instret, exp_instret);
    chk("perf_wait", perf_wait, exp_wait);
`endif
  endtask

  // one full transaction starting in the request phase
  task automatic fetch_one(input int waits, input int stalls, input logic j,
                           input logic s, input logic [31:0] br, input logic [31:0] w);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0; bus.imem_rdata = $urandom;
      pcsrc = 1'($urandom); jump = 1'($urandom); pcbranch = $urandom; stall = 1'($urandom);
      chk("wait_req", 32'(bus.imem_req), 32'd1);
      chk("wait_addr", bus.imem_addr, exp_pc);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      cyc();
      exp_wait++;
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = w;
    pcsrc = 1'($urandom); jump = 1'($urandom); pcbranch = $urandom;
    chk("ack_req", 32'(bus.imem_req), 32'd1);
    chk("ack_addr", bus.imem_addr, exp_pc);
    chk("ack_pc", pc, exp_pc);
    cyc();
    for (int k = 0; k < stalls; k++) begin
      bus.imem_ack = 1'($urandom); bus.imem_rdata = $urandom;
      stall = 1'b1; pcsrc = 1'($urandom); jump = 1'($urandom); pcbranch = $urandom;
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, w);
      chk("stall_pc", pc, exp_pc);
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      cyc();
      exp_wait++;
    end
    bus.imem_ack = 1'($urandom); bus.imem_rdata = $urandom;
    stall = 1'b0; jump = j; pcsrc = s; pcbranch = br;
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_instr", instr, w);
    chk("hold_op", 32'(op), 32'(w[31:26]));
    chk("hold_funct", 32'(funct), 32'(w[5:0]));
    chk("hold_pc", pc, exp_pc);
    chk("hold_pc4", pc4, exp_pc + 32'd4);
    chk("hold_req", 32'(bus.imem_req), 32'd0);
    cyc();
    bus.imem_ack = 1'b0;
    exp_pc = ref_next(exp_pc, w, j, s, br);
    exp_instret++;
    chk_perf();
  endtask

  // asynchronous reset from wherever we are, then a stray ack in the idle cycle
  task automatic do_reset(input logic stray);
    reset = 1'b0;
    #1;
    exp_instret = 0; exp_wait = 0;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk_perf();
    cyc();
    cyc();
    reset = 1'b1;
    bus.imem_ack = stray; bus.imem_rdata = $urandom;
    #1;
    chk("idle_req", 32'(bus.imem_req), 32'd0);
    chk("idle_valid", 32'(instr_valid), 32'd0);
    cyc();
    bus.imem_ack = 1'b0;
    exp_pc = 32'h0;
  endtask

  int wt[5] = '{0, 1, 0, 2, 0};
  int st[5] = '{1, 0, 0, 0, 1};

  initial begin
    reset = 1'b1; stall = 1'b0; pcsrc = 1'b0; jump = 1'b0; pcbranch = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    exp_pc = 0; exp_instret = 0; exp_wait = 0;
    #2;
    do_reset(1'b0);

    // zero-wait sequential fetches: 0x0, 0x4, 0x8, 0xC
    for (int i = 0; i < 4; i++) fetch_one(0, 0, 1'b0, 1'b0, 32'h0, $urandom);
    // delayed ack
    fetch_one(3, 0, 1'b0, 1'b0, 32'h0, $urandom);
    // misaligned branch target to 0x20
    fetch_one(0, 0, 1'b0, 1'b1, 32'h23, $urandom);
    // branch with stall from 0x20 to 0x30
    fetch_one(0, 2, 1'b0, 1'b1, 32'h30, 32'h1040_0003);
    chk("branch_target_model", exp_pc, 32'h30);
    fetch_one(0, 0, 1'b0, 1'b1, 32'h40, $urandom);
    // jump beats branch, lands at 0x40
    fetch_one(0, 0, 1'b1, 1'b1, 32'h1234, 32'h0800_0010);
    // wrap boundary
    fetch_one(0, 0, 1'b0, 1'b1, 32'hFFFF_FFFD, $urandom);
    fetch_one(1, 1, 1'b0, 1'b0, 32'h0, $urandom);
    // jump from a high region keeps pc4[31:28]
    fetch_one(0, 0, 1'b0, 1'b1, 32'hF000_0010, $urandom);
    fetch_one(0, 0, 1'b1, 1'b0, 32'h0, $urandom);

    for (int n = 0; n < 40; n++)
      fetch_one($urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom),
                $urandom, $urandom);

    // reset during REQ with a stray ack after release
    chk("pre_rst_req", 32'(bus.imem_req), 32'd1);
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) fetch_one(wt[i], st[i], 1'b0, 1'b0, 32'h0, $urandom);
`ifdef FETCH_PERF_EN
    chk("perf5_instret", perf_instret, 32'd5);
    chk("perf5_wait", perf_wait, 32'd5);
`endif

    // reset during HOLD
    bus.imem_ack = 1'b1; bus.imem_rdata = $urandom;
    cyc();
    bus.imem_ack = 1'b0; stall = 1'b1;
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    do_reset(1'b1);
    stall = 1'b0;
    fetch_one(0, 1, 1'b0, 1'b0, 32'h0, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
